// File: rtl/bounce_gen.sv
// bounce_gen: mechanical-switch bounce emulator.
// When level_in differs from sw_out, sw_out chatters for 2*BOUNCES+1 toggles
// spaced D cycles apart, then holds the new level for a 2^N-cycle settle
// window before returning to IDLE with a one-cycle done_tick.
// Optional feature macro: BOUNCE_GEN_RANDOM_EN (LFSR-driven hold durations).
module bounce_gen #(
  parameter int          N       = 2,
  parameter int          BOUNCES = 3,
  parameter int          HOLD_W  = 2,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic clk,
  input  logic reset,
  input  logic level_in,
  output logic sw_out,
  output logic busy,
  output logic done_tick
);

  localparam int TOG_W = $clog2(2 * BOUNCES + 1);
  localparam logic [TOG_W-1:0] TOG_LOAD    = TOG_W'(2 * BOUNCES);
  localparam logic [TOG_W-1:0] TOG_LAST    = TOG_W'(1);
  localparam logic [N-1:0]     SETTLE_LOAD = {N{1'b1}};

  // Reject parameter sets the counters cannot represent.
  if (N < 1 || BOUNCES < 1 || HOLD_W < 1 || HOLD_W > 16 || SEED == 16'h0000) begin : g_param_check
    $error("bounce_gen: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t            state_q,  state_d;
  logic              sw_q,     sw_d;
  logic              done_q,   done_d;
  logic [TOG_W-1:0]  tog_q,    tog_d;
  logic [HOLD_W-1:0] hold_q,   hold_d;
  logic [N-1:0]      settle_q, settle_d;
  logic [HOLD_W-1:0] hold_load;

`ifdef BOUNCE_GEN_RANDOM_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, free-running every cycle.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR register; reset value makes the hold sequence reproducible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Hold counter is loaded with D-1, so D = low bits + 1 spans 1..2^HOLD_W.
  assign hold_load = lfsr_q[HOLD_W-1:0];
`else
  // Fixed hold D = 2^(HOLD_W-1); counter is loaded with D-1.
  assign hold_load = HOLD_W'((1 << (HOLD_W - 1)) - 1);
`endif

  // Next-state and counter logic for the IDLE/BOUNCE/SETTLE sequencer.
  always_comb begin
    state_d  = state_q;
    sw_d     = sw_q;
    done_d   = 1'b0;
    tog_d    = tog_q;
    hold_d   = hold_q;
    settle_d = settle_q;
    case (state_q)
      IDLE: begin
        if (level_in != sw_q) begin
          // First toggle happens on the detecting edge itself.
          state_d = BOUNCE;
          sw_d    = ~sw_q;
          tog_d   = TOG_LOAD;
          hold_d  = hold_load;
        end
      end
      BOUNCE: begin
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (tog_q != '0) begin
          sw_d   = ~sw_q;
          tog_d  = tog_q - 1'b1;
          hold_d = hold_load;
          if (tog_q == TOG_LAST) begin
            state_d  = SETTLE;
            settle_d = SETTLE_LOAD;
          end
        end else begin
          // Unreachable with legal loads; fall through to settle rather than stall.
          state_d  = SETTLE;
          settle_d = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (settle_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, output and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sw_q     <= 1'b0;
      done_q   <= 1'b0;
      tog_q    <= '0;
      hold_q   <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      sw_q     <= sw_d;
      done_q   <= done_d;
      tog_q    <= tog_d;
      hold_q   <= hold_d;
      settle_q <= settle_d;
    end
  end

  assign sw_out    = sw_q;
  assign done_tick = done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bounce_gen.sv
// Testbench for bounce_gen: table-driven transition waveforms, hand-written
// corner sequences, and randomized level requests checked against a
// time-since-request reference model (fixed-hold build). With
// BOUNCE_GEN_RANDOM_EN defined, random-hold properties are checked instead.
module tb_bounce_gen;

  localparam int N   = 2;
  localparam int B   = 3;
  localparam int HW  = 2;
  localparam int D   = 1 << (HW - 1);
  localparam int SEQ = 2 * B * D + (1 << N);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic level_in = 1'b0;
  logic sw_out, busy, done_tick;

  bounce_gen #(.N(N), .BOUNCES(B), .HOLD_W(HW), .SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset), .level_in(level_in),
    .sw_out(sw_out), .busy(busy), .done_tick(done_tick)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Reference model: edges elapsed since the request edge E0.
  bit m_act = 1'b0;
  bit m_sw = 1'b0;
  bit m_done = 1'b0;
  int m_t = 0;

  typedef struct {
    logic lvl;
    logic e_sw;
    logic e_busy;
    logic e_done;
  } vec_t;
  vec_t tbl[36];

  task automatic check1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0b expected %0b", name, cyc, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  // Toggles fall on t = 0, D, 2D, ... 2B*D; done is flagged at t = 2B*D + 2^N.
  function automatic void model_edge(input logic lvl);
    m_done = 1'b0;
    if (!m_act) begin
      if (lvl != m_sw) begin
        m_act = 1'b1;
        m_t   = 0;
        m_sw  = ~m_sw;
      end
    end else begin
      m_t++;
      if ((m_t % D) == 0 && (m_t / D) <= 2 * B) m_sw = ~m_sw;
      if (m_t == SEQ) begin
        m_act  = 1'b0;
        m_done = 1'b1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge(level_in);
    cyc++;
    #1;
`ifndef BOUNCE_GEN_RANDOM_EN
    check1("sw_out", sw_out, m_sw);
    check1("busy", busy, m_act);
    check1("done_tick", done_tick, m_done);
`endif
    if (done_tick) $display("cycle %0d: sequence complete, sw_out=%0b", cyc, sw_out);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    m_act = 1'b0; m_sw = 1'b0; m_done = 1'b0; m_t = 0;
    check1("reset sw_out", sw_out, 1'b0);
    check1("reset busy", busy, 1'b0);
    check1("reset done_tick", done_tick, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    $display("cycle %0d: reset applied and released", cyc);
  endtask

  // Hold level_in and step until the block rests idle at the requested level.
  task automatic run_until_idle(input int max_cycles);
    int k;
    k = 0;
    while (k < max_cycles && (busy || done_tick || sw_out != level_in)) begin
      tick();
      k++;
    end
    check_int("idle reached within bound", int'(k < max_cycles), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] sw_bits;
    logic [17:0] busy_bits;
    logic [17:0] done_bits;
    int dn, tg, bad;
    logic prev;

    // Expected waveform after each edge E0..E17 for a 0->1 request (bit i = Ei).
    sw_bits   = 18'b111111001100110011;
    busy_bits = 18'b001111111111111111;
    done_bits = 18'b010000000000000000;
    for (int i = 0; i < 18; i++) begin
      tbl[i]      = '{lvl: 1'b1, e_sw: sw_bits[i],  e_busy: busy_bits[i], e_done: done_bits[i]};
      tbl[i + 18] = '{lvl: 1'b0, e_sw: ~sw_bits[i], e_busy: busy_bits[i], e_done: done_bits[i]};
    end

    do_reset();

`ifndef BOUNCE_GEN_RANDOM_EN
    // 0->1 then 1->0 transitions against the literal waveform table.
    for (int i = 0; i < 36; i++) begin
      level_in = tbl[i].lvl;
      tick();
      check1("table sw_out", sw_out, tbl[i].e_sw);
      check1("table busy", busy, tbl[i].e_busy);
      check1("table done_tick", done_tick, tbl[i].e_done);
    end
    $display("cycle %0d: table transitions done", cyc);

    // Request pulses 0->1->0 during BOUNCE: finish at 1, then restart toward 0.
    dn = 0;
    level_in = 1'b1;
    tick(); tick();
    level_in = 1'b0;
    for (int i = 0; i < 38; i++) begin
      tick();
      if (done_tick) dn++;
    end
    check_int("pulse done count", dn, 2);
    check1("pulse final level", sw_out, 1'b0);
`endif

    // Reset at E5 of a 0->1 sequence, then restart since level_in=1.
    level_in = 1'b1;
    repeat (6) tick();
    do_reset();
    tick();
    check1("restart busy", busy, 1'b1);
    check1("restart first toggle", sw_out, 1'b1);
    run_until_idle(200);
    check1("restart final level", sw_out, 1'b1);

`ifndef BOUNCE_GEN_RANDOM_EN
    // Randomized requests against the reference model.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 11) == 0) level_in = ~level_in;
      tick();
    end
    run_until_idle(200);
`else
    // Random holds: reproducible from reset, gaps in 1..2^HW, 7 toggles.
    begin
      int edges[2][$];
      for (int r = 0; r < 2; r++) begin
        int c;
        bit seen;
        level_in = 1'b0;
        do_reset();
        level_in = 1'b1;
        prev = sw_out;
        seen = 1'b0;
        c = 0;
        while (c < 200 && !seen) begin
          tick();
          if (sw_out != prev) edges[r].push_back(c);
          prev = sw_out;
          if (done_tick) seen = 1'b1;
          c++;
        end
        check_int("random run completed", int'(seen), 1);
        check_int("random toggle count", edges[r].size(), 2 * B + 1);
        check1("random final level", sw_out, 1'b1);
        bad = 0;
        for (int i = 1; i < edges[r].size(); i++) begin
          if (edges[r][i] - edges[r][i-1] < 1 || edges[r][i] - edges[r][i-1] > (1 << HW)) bad++;
        end
        check_int("random gaps in range", bad, 0);
      end
      bad = 0;
      for (int i = 0; i < edges[0].size() && i < edges[1].size(); i++) begin
        if (edges[0][i] != edges[1][i]) bad++;
      end
      check_int("random reproducible", bad, 0);
      run_until_idle(200);
    end
`endif

    // Idle stability with level_in equal to sw_out.
    level_in = sw_out;
    prev = sw_out;
    tg = 0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (sw_out != prev) tg++;
      prev = sw_out;
      if (busy || done_tick) bad++;
    end
    check_int("idle toggles", tg, 0);
    check_int("idle busy/done", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bounce_gen.md
# bounce_gen

Synthesizable mechanical-switch bounce emulator: converts a clean level request into a bouncing switch waveform. When the requested level changes, the output chatters for a fixed number of toggles, then holds the new level stable for a settle window. It sits in on-board self-test and simulation harnesses ahead of the switch debouncer, so the debouncer can be exercised without physical switches.

## Interface
- `N`, default 2: settle window is 2^N cycles. Use 2 for simulation and 20 for synthesis; N ≥ 1.
- `BOUNCES`, default 3: the output toggles 2*BOUNCES+1 times per transition; BOUNCES ≥ 1.
- `HOLD_W`, default 2: width of the hold counter between toggles; 1 ≤ HOLD_W ≤ 16.
- `SEED`, default 16'hACE1: LFSR reset value; must be nonzero.
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `level_in`  in  1  requested clean switch level; synchronous to clk.
- `sw_out`  out  1  emulated bouncing switch output; registered.
- `busy`  out  1  high whenever the state is not IDLE.
- `done_tick`  out  1  one-cycle pulse on return to IDLE; registered.

## Operation
- States:
  - IDLE: sw_out holds its stable level.
  - BOUNCE: chatter phase.
  - SETTLE: sw_out held at the target level.
- IDLE → BOUNCE: taken at the first rising edge where level_in ≠ sw_out (call it E0).
  - At E0, sw_out toggles (toggle 1), the toggle counter is loaded with 2*BOUNCES, and the hold counter is loaded with D−1.
- BOUNCE:
  - The hold counter decrements each edge.
  - At an edge where hold = 0 and toggles remaining > 0: toggle sw_out, decrement toggles remaining, reload hold with D−1.
  - The toggle that makes remaining = 0 moves the block to SETTLE and loads the settle counter with 2^N−1.
  - Successive toggles are therefore D cycles apart. The toggle count is odd, so sw_out ends at the requested level.
- SETTLE:
  - The settle counter decrements each edge.
  - At the edge where it is 0: go to IDLE and set done_tick=1 for exactly one cycle.
- level_in is ignored while busy.
  - In IDLE it is compared again every edge. A request that changed during operation starts a new sequence at the edge after done_tick.
  - IDLE therefore always lasts at least one cycle between sequences.
- Hold duration D (HOLD_W-bit counter):
  - Random mode: D = lfsr[HOLD_W−1:0] + 1, giving the range 1..2^HOLD_W. D is sampled at each load.
  - Fixed mode: D = 2^(HOLD_W−1).
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifting every cycle.
  - Present only when random mode is compiled in.
- Toggle counter width is $clog2(2*BOUNCES+1). Every counter decrements without wrap: the load/expire rules above prevent underflow.

## Timing
- Reset values, all asynchronous:
  - sw_out=0, busy=0, done_tick=0.
  - State IDLE; all counters 0; LFSR=SEED.
- Reset mid-BOUNCE or mid-SETTLE aborts immediately to the reset values. sw_out=0 even if a transition to 1 was in progress.
- busy is decoded from the state register. It rises the cycle after E0 and falls in the same cycle that done_tick rises.
- Fixed-mode latency from E0 to the done_tick edge: 2*BOUNCES*D + 2^N edges.
- sw_out never changes during SETTLE or IDLE. It changes in BOUNCE only at toggle edges.
- done_tick is never asserted outside the first IDLE cycle after SETTLE.

## Configuration
- Macro `BOUNCE_GEN_RANDOM_EN`:
  - Defined: the LFSR is instantiated and hold durations are pseudo-random (1..2^HOLD_W). With a fixed SEED the sequence is reproducible after reset.
  - Undefined: no LFSR logic. Every hold is D = 2^(HOLD_W−1) and the waveform is fully deterministic. The SEED parameter is unused.

## Test plan
- Fixed mode, N=2, BOUNCES=3, HOLD_W=2; reset, then level_in 0→1:
  - sw_out toggles at E0, E2, E4, E6, E8, E10, E12 and ends at 1.
  - Stable E12..E16; done_tick high for the single cycle after E16.
  - busy high from E0+1 through E16.
- Same configuration, level_in 1→0 after the first sequence:
  - Mirror waveform ending at 0; same 16-edge latency to done_tick.
- level_in pulses 0→1→0 within 3 cycles during BOUNCE:
  - Sequence completes at 1, then a new sequence starts at the edge after done_tick and ends at 0.
- Reset asserted at E5 of a 0→1 sequence:
  - sw_out=0, busy=0, done_tick=0 immediately.
  - After release, a new sequence starts because level_in=1 ≠ sw_out=0.
- Random mode, HOLD_W=3, two runs from reset with the same stimulus:
  - Identical toggle edges.
  - Every inter-toggle gap within 1..8 cycles; 7 toggles; final level correct.
- Idle stability: level_in held equal to sw_out for 100 cycles → no toggles, busy=0, done_tick=0 throughout.
